markov_first_build: RTL and testbench

//  Upstream producer for the first-order Markov merge stage. Walks a note sequence in

---
 rtl/markov_first_build.sv | 192 +++++++++++++++++++
 tb/tb_markov_first_build.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/markov_first_build.sv
// Builds a first-order transition list {prev, next, count} from a note sequence in RAM.
// Addresses are presented combinationally so that synchronous RAM data is ready the next cycle.
module markov_first_build #(
  parameter int NOTE_W  = 8,
  parameter int CNT_W   = 8,
  parameter int SEQ_AW  = 8,
  parameter int LIST_AW = 6,
  parameter int MAX_ENT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SEQ_AW:0]            seq_len,
  output logic [SEQ_AW-1:0]          seq_addr,
  input  logic [NOTE_W-1:0]          seq_data,
  output logic [LIST_AW-1:0]         list_addr,
  input  logic [2*NOTE_W+CNT_W-1:0]  list_rdata,
  output logic                       list_we,
  output logic [2*NOTE_W+CNT_W-1:0]  list_wdata,
  output logic [LIST_AW:0]           list_len,
  output logic                       overflow,
  output logic                       saturated,
  output logic                       busy,
  output logic                       done
);

  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [LIST_AW:0]   LEN_CAP = (LIST_AW+1)'(MAX_ENT);
  localparam logic [SEQ_AW:0]    MIN_LEN = (SEQ_AW+1)'(2);

  typedef enum logic [2:0] {
    IDLE, RD_FIRST, RD_NEXT, SEARCH_CMP, INCREMENT, APPEND, ADVANCE, FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [SEQ_AW:0]     len_q, len_d;
  logic [SEQ_AW:0]     i_q, i_d;
  logic [LIST_AW-1:0]  j_q, j_d;
  logic [NOTE_W-1:0]   prev_q, prev_d;
  logic [NOTE_W-1:0]   nxt_q, nxt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LIST_AW:0]    list_len_q, list_len_d;
  logic                overflow_q, overflow_d;
  logic                saturated_q, saturated_d;
  logic [SEQ_AW-1:0]   seq_addr_q, seq_addr_d;
  logic [LIST_AW-1:0]  list_addr_q, list_addr_d;

  logic [CNT_W-1:0]    inc_cnt;
  logic                list_full;
  logic [SEQ_AW:0]     i_next;
  logic [LIST_AW:0]    j_next;

  assign inc_cnt   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign list_full = (list_len_q >= LEN_CAP);
  assign i_next    = i_q + 1'b1;
  assign j_next    = {1'b0, j_q} + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      prev_q      <= '0;
      nxt_q       <= '0;
      cnt_q       <= '0;
      list_len_q  <= '0;
      overflow_q  <= 1'b0;
      saturated_q <= 1'b0;
      seq_addr_q  <= '0;
      list_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      i_q         <= i_d;
      j_q         <= j_d;
      prev_q      <= prev_d;
      nxt_q       <= nxt_d;
      cnt_q       <= cnt_d;
      list_len_q  <= list_len_d;
      overflow_q  <= overflow_d;
      saturated_q <= saturated_d;
      seq_addr_q  <= seq_addr_d;
      list_addr_q <= list_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    i_d         = i_q;
    j_d         = j_q;
    prev_d      = prev_q;
    nxt_d       = nxt_q;
    cnt_d       = cnt_q;
    list_len_d  = list_len_q;
    overflow_d  = overflow_q;
    saturated_d = saturated_q;
    seq_addr_d  = seq_addr_q;
    list_addr_d = list_addr_q;
    case (state_q)
      IDLE: if (start) begin
        len_d       = seq_len;
        list_len_d  = '0;
        overflow_d  = 1'b0;
        saturated_d = 1'b0;
        i_d         = '0;
        if (seq_len < MIN_LEN) begin
          state_d = FINISH;
        end else begin
          seq_addr_d = '0;
          state_d    = RD_FIRST;
        end
      end
      RD_FIRST: begin
        prev_d     = seq_data;
        i_d        = (SEQ_AW+1)'(1);
        seq_addr_d = SEQ_AW'(1);
        state_d    = RD_NEXT;
      end
      RD_NEXT: begin
        nxt_d = seq_data;
        j_d   = '0;
        if (list_len_q == '0) begin
          state_d = APPEND;
        end else begin
          list_addr_d = '0;
          state_d     = SEARCH_CMP;
        end
      end
      SEARCH_CMP: begin
        if (list_rdata[2*NOTE_W+CNT_W-1:CNT_W] == {prev_q, nxt_q}) begin
          cnt_d   = list_rdata[CNT_W-1:0];
          state_d = INCREMENT;
        end else if (j_next < list_len_q) begin
          j_d         = j_next[LIST_AW-1:0];
          list_addr_d = j_next[LIST_AW-1:0];
        end else begin
          state_d = APPEND;
        end
      end
      INCREMENT: begin
        list_addr_d = j_q;
        if (inc_cnt == CNT_MAX) saturated_d = 1'b1;
        state_d = ADVANCE;
      end
      APPEND: begin
        // A full list keeps counting known pairs but drops new ones
        if (!list_full) begin
          list_addr_d = list_len_q[LIST_AW-1:0];
          list_len_d  = list_len_q + 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
        state_d = ADVANCE;
      end
      ADVANCE: begin
        prev_d = nxt_q;
        i_d    = i_next;
        if (i_next == len_q) begin
          state_d = FINISH;
        end else begin
          seq_addr_d = i_next[SEQ_AW-1:0];
          state_d    = RD_NEXT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    list_we    = 1'b0;
    list_wdata = '0;
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
    if (state_q == INCREMENT) begin
      list_we    = 1'b1;
      list_wdata = {prev_q, nxt_q, inc_cnt};
    end else if (state_q == APPEND && !list_full) begin
      list_we    = 1'b1;
      list_wdata = {prev_q, nxt_q, CNT_W'(1)};
    end
  end

  assign seq_addr  = seq_addr_d;
  assign list_addr = list_addr_d;
  assign list_len  = list_len_q;
  assign overflow  = overflow_q;
  assign saturated = saturated_q;

endmodule

// File: tb/tb_markov_first_build.sv
// Bench for markov_first_build: a default-size build unit and a tiny one (2-bit counts, 2 entries),
// both fed from synchronous RAM models and compared against a pair-counting reference.
module tb_markov_first_build;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] seq_mem [256];

  logic        start_a, start_b;
  logic [8:0]  seq_len_a, seq_len_b;
  logic [7:0]  seq_addr_a, seq_addr_b, seq_data_a, seq_data_b;
  logic [5:0]  list_addr_a, list_addr_b;
  logic [23:0] list_rdata_a, list_wdata_a;
  logic [17:0] list_rdata_b, list_wdata_b;
  logic [23:0] list_mem_a [64];
  logic [17:0] list_mem_b [64];
  logic        list_we_a, list_we_b;
  logic [6:0]  list_len_a, list_len_b;
  logic        overflow_a, overflow_b, saturated_a, saturated_b;
  logic        busy_a, busy_b, done_a, done_b;

  markov_first_build dut_a (
    .clk(clk), .reset(reset), .start(start_a), .seq_len(seq_len_a),
    .seq_addr(seq_addr_a), .seq_data(seq_data_a), .list_addr(list_addr_a),
    .list_rdata(list_rdata_a), .list_we(list_we_a), .list_wdata(list_wdata_a),
    .list_len(list_len_a), .overflow(overflow_a), .saturated(saturated_a),
    .busy(busy_a), .done(done_a)
  );

  markov_first_build #(.CNT_W(2), .MAX_ENT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .seq_len(seq_len_b),
    .seq_addr(seq_addr_b), .seq_data(seq_data_b), .list_addr(list_addr_b),
    .list_rdata(list_rdata_b), .list_we(list_we_b), .list_wdata(list_wdata_b),
    .list_len(list_len_b), .overflow(overflow_b), .saturated(saturated_b),
    .busy(busy_b), .done(done_b)
  );

  // Synchronous-read RAMs; read data lags the address by one cycle
  always @(posedge clk) begin
    seq_data_a <= seq_mem[seq_addr_a];
    seq_data_b <= seq_mem[seq_addr_b];
    if (list_we_a) list_mem_a[list_addr_a] <= list_wdata_a;
    list_rdata_a <= list_mem_a[list_addr_a];
    if (list_we_b) list_mem_b[list_addr_b] <= list_wdata_b;
    list_rdata_b <= list_mem_b[list_addr_b];
  end

  int done_cnt_a = 0, done_cnt_b = 0, we_cnt_a = 0;
  always @(posedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
    if (list_we_a === 1'b1) we_cnt_a++;
  end

  int tests_run = 0, tests_failed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: distinct pairs in first-seen order, saturating counts, capacity-limited
  int ref_len;
  bit ref_ovf, ref_sat;
  logic [7:0] ref_prev [256];
  logic [7:0] ref_next [256];
  int ref_cnt [256];

  task automatic buildModel(input int len, input int cap, input int cmax);
    int found;
    ref_len = 0; ref_ovf = 0; ref_sat = 0;
    for (int k = 1; k < len; k++) begin
      found = -1;
      for (int e = 0; e < ref_len; e++)
        if (ref_prev[e] == seq_mem[k-1] && ref_next[e] == seq_mem[k]) found = e;
      if (found >= 0) begin
        if (ref_cnt[found] < cmax) ref_cnt[found]++;
        if (ref_cnt[found] == cmax) ref_sat = 1;
      end else if (ref_len < cap) begin
        ref_prev[ref_len] = seq_mem[k-1];
        ref_next[ref_len] = seq_mem[k];
        ref_cnt[ref_len]  = 1;
        ref_len++;
      end else begin
        ref_ovf = 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit use_b, input int len, output int cycles, output bit timed_out);
    if (use_b) begin seq_len_b = 9'(len); start_b = 1'b1; end
    else       begin seq_len_a = 9'(len); start_a = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    cycles = 1;
    while (!(use_b ? done_b : done_a) && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
    end
    timed_out = !(use_b ? done_b : done_a);
  endtask

  task automatic checkBuild(input bit use_b, input string tag, input int len);
    logic [63:0] exp_e, act_e;
    buildModel(len, use_b ? 2 : 64, use_b ? 3 : 255);
    checkOutput({tag, " list_len"}, use_b ? 64'(list_len_b) : 64'(list_len_a), 64'(ref_len));
    checkOutput({tag, " overflow"}, use_b ? 64'(overflow_b) : 64'(overflow_a), 64'(ref_ovf));
    checkOutput({tag, " saturated"}, use_b ? 64'(saturated_b) : 64'(saturated_a), 64'(ref_sat));
    for (int k = 0; k < ref_len; k++) begin
      if (use_b) begin
        exp_e = 64'({ref_prev[k], ref_next[k], 2'(ref_cnt[k])});
        act_e = 64'(list_mem_b[k]);
      end else begin
        exp_e = 64'({ref_prev[k], ref_next[k], 8'(ref_cnt[k])});
        act_e = 64'(list_mem_a[k]);
      end
      checkOutput($sformatf("%s entry%0d", tag, k), act_e, exp_e);
    end
  endtask

  task automatic runAndCheck(input bit use_b, input string tag, input int len);
    int cyc, d0;
    bit to;
    d0 = use_b ? done_cnt_b : done_cnt_a;
    applyStimulus(use_b, len, cyc, to);
    checkOutput({tag, " timeout"}, 64'(to), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, " done pulses"}, 64'((use_b ? done_cnt_b : done_cnt_a) - d0), 64'd1);
    checkOutput({tag, " busy after"}, use_b ? 64'(busy_b) : 64'(busy_a), 64'd0);
    checkBuild(use_b, tag, len);
  endtask

  typedef struct {
    int          len;
    logic [63:0] notes;
    int          exp_len;
    bit          exp_ovf;
    bit          exp_sat;
  } vec_t;

  vec_t vecs [7];

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " A outputs"},
      64'({seq_addr_a, list_addr_a, list_we_a, list_wdata_a, list_len_a, overflow_a, saturated_a, busy_a, done_a}), 64'd0);
    checkOutput({tag, " B outputs"},
      64'({seq_addr_b, list_addr_b, list_we_b, list_len_b, overflow_b, saturated_b, busy_b, done_b}), 64'd0);
  endtask

  initial begin
    int cyc, we0, d0;
    bit to;
    logic [7:0] alpha;

    vecs[0] = '{4, 64'h0000_0000_3E3C_3E3C, 2, 0, 0};
    vecs[1] = '{1, 64'h0000_0000_0000_003C, 0, 0, 0};
    vecs[2] = '{0, 64'h0000_0000_0000_0000, 0, 0, 0};
    vecs[3] = '{5, 64'h0000_0001_0201_0201, 2, 0, 0};
    vecs[4] = '{3, 64'h0000_0000_0005_0505, 1, 0, 0};
    vecs[5] = '{8, 64'h0807_0605_0403_0201, 7, 0, 0};
    vecs[6] = '{2, 64'h0000_0000_0000_0909, 1, 0, 0};

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; seq_len_a = '0; seq_len_b = '0;
    for (int k = 0; k < 256; k++) seq_mem[k] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleZero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 8; k++) seq_mem[k] = vecs[v].notes[8*k +: 8];
      we0 = we_cnt_a;
      d0  = done_cnt_a;
      applyStimulus(1'b0, vecs[v].len, cyc, to);
      checkOutput($sformatf("vec%0d timeout", v), 64'(to), 64'd0);
      if (vecs[v].len < 2) begin
        checkOutput($sformatf("vec%0d short done latency", v), 64'(cyc), 64'd1);
        checkOutput($sformatf("vec%0d short no writes", v), 64'(we_cnt_a - we0), 64'd0);
      end
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d done pulses", v), 64'(done_cnt_a - d0), 64'd1);
      checkOutput($sformatf("vec%0d list_len", v), 64'(list_len_a), 64'(vecs[v].exp_len));
      checkOutput($sformatf("vec%0d overflow", v), 64'(overflow_a), 64'(vecs[v].exp_ovf));
      checkOutput($sformatf("vec%0d saturated", v), 64'(saturated_a), 64'(vecs[v].exp_sat));
      checkBuild(1'b0, $sformatf("vec%0d", v), vecs[v].len);
      if (v == 0) begin
        checkOutput("example entry0", 64'(list_mem_a[0]), 64'({8'd60, 8'd62, 8'd2}));
        checkOutput("example entry1", 64'(list_mem_a[1]), 64'({8'd62, 8'd60, 8'd1}));
      end
    end

    // Small alphabets exercise matching; long wide-alphabet runs fill the list
    for (int r = 0; r < 12; r++) begin
      int len;
      len   = (r < 9) ? int'($urandom_range(2, 40)) : 200;
      alpha = (r < 9) ? 8'd5 : 8'd15;
      for (int k = 0; k < len; k++) seq_mem[k] = 8'($urandom_range(0, int'(alpha)));
      runAndCheck(1'b0, $sformatf("rand%0d", r), len);
    end

    for (int k = 0; k < 256; k++) seq_mem[k] = 8'd7;
    runAndCheck(1'b0, "sat256", 256);
    checkOutput("sat256 entry", 64'(list_mem_a[0]), 64'({8'd7, 8'd7, 8'd255}));

    for (int k = 0; k < 6; k++) seq_mem[k] = 8'd60;
    runAndCheck(1'b1, "smallsat", 6);
    checkOutput("smallsat entry", 64'(list_mem_b[0]), 64'({8'd60, 8'd60, 2'd3}));
    checkOutput("smallsat flag", 64'(saturated_b), 64'd1);

    for (int k = 0; k < 4; k++) seq_mem[k] = 8'(k + 1);
    runAndCheck(1'b1, "smallovf", 4);
    checkOutput("smallovf entry0", 64'(list_mem_b[0]), 64'({8'd1, 8'd2, 2'd1}));
    checkOutput("smallovf entry1", 64'(list_mem_b[1]), 64'({8'd2, 8'd3, 2'd1}));
    checkOutput("smallovf flag", 64'(overflow_b), 64'd1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 20; k++) seq_mem[k] = 8'($urandom_range(0, 2));
      runAndCheck(1'b1, $sformatf("smallrand%0d", r), 20);
    end

    // Reset in the middle of a build, then a clean rebuild
    for (int k = 0; k < 40; k++) seq_mem[k] = 8'($urandom_range(0, 4));
    seq_len_a = 9'd40; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midbuild busy", 64'(busy_a), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    checkIdleZero("midreset");
    reset = 1'b1;
    @(posedge clk); #1;
    runAndCheck(1'b0, "after reset", 40);

    // start while busy and in the FINISH cycle must not launch another build
    for (int k = 0; k < 30; k++) seq_mem[k] = 8'($urandom_range(0, 4));
    d0 = done_cnt_a;
    seq_len_a = 9'd30; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    seq_len_a = 9'd3; start_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("ignore timeout", 64'(done_a), 64'd1);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checkOutput("finish start busy", 64'(busy_a), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ignore done pulses", 64'(done_cnt_a - d0), 64'd1);
    checkOutput("ignore idle", 64'(busy_a), 64'd0);
    checkBuild(1'b0, "ignore", 30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
